dadda_pipe: RTL and testbench

- Parametrised, pipelined successor to the blitter data-path adder operand-A selector.
- Selects one of the destination or NSRC source phrases per transfer, then applies a lane mode (pass, broadcast, half-swap) and a per-lane zero mask.
- Delivers the result as a LANES x LW operand phrase over a valid/ready handshake.
- Sits between the blitter data registers and the data adder; allows register retiming ahead of the adder and back-pressure from it.

---
 rtl/dadda_pipe_if.sv | 33 +++
 rtl/dadda_pipe.sv | 134 +++++++++++++
 tb/tb_dadda_pipe.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dadda_pipe_if.sv
// Handshake and data bundle for the blitter adder operand-A pipeline.
// Slave is the pipeline's view; master is the producer/consumer environment's view.
interface dadda_pipe_if #(
    parameter int LW    = 16,
    parameter int LANES = 4,
    parameter int NSRC  = 5,
    parameter int SELW  = 3
);
    localparam int PW = LANES * LW;

    logic                 in_valid;
    logic                 in_ready;
    logic [PW-1:0]        dstd;
    logic [NSRC*PW-1:0]   srcs;
    logic [SELW-1:0]      sel;
    logic [1:0]           mode;
    logic [LANES-1:0]     lane_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [PW-1:0]        adda;

    // Valid/ready: a beat moves on a rising edge where valid && ready; the
    // sender holds valid and payload until then, and ready never waits on valid.
    modport slave (
        input  in_valid, dstd, srcs, sel, mode, lane_en, out_ready,
        output in_ready, out_valid, adda
    );

    modport master (
        output in_valid, dstd, srcs, sel, mode, lane_en, out_ready,
        input  in_ready, out_valid, adda
    );
endinterface

// File: rtl/dadda_pipe.sv
// Two-stage operand-A selector: stage 1 picks dstd or a source phrase,
// stage 2 applies the lane mode then the lane mask and drives adda.
module dadda_pipe #(
    parameter int LW    = 16,
    parameter int LANES = 4,
    parameter int NSRC  = 5,
    parameter int SELW  = 3
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    dadda_pipe_if.slave          bus,
    output logic                 illegal_sel,
    output logic [15:0]          xfer_cnt
);
    localparam int PW   = LANES * LW;
    localparam int HALF = LANES / 2;

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_BCAST = 2'b01;
    localparam logic [1:0] MODE_SWAP  = 2'b10;

    logic              s1_valid_q, s1_valid_d;
    logic [PW-1:0]     s1_data_q, s1_data_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic [LANES-1:0]  s1_lane_en_q, s1_lane_en_d;
    logic              out_valid_q, out_valid_d;
    logic [PW-1:0]     adda_q, adda_d;
    logic              illegal_q, illegal_d;
    logic [15:0]       xfer_cnt_q, xfer_cnt_d;

    logic              s2_adv;
    logic              accept;
    logic              drain;
    logic              sel_bad;
    logic [PW-1:0]     sel_phrase;
    logic [PW-1:0]     shaped;

    assign s2_adv = s1_valid_q && (!out_valid_q || bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;
    assign drain  = out_valid_q && bus.out_ready;

    assign bus.in_ready  = !s1_valid_q || s2_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.adda      = adda_q;
    assign illegal_sel   = illegal_q;
    assign xfer_cnt      = xfer_cnt_q;

    // Source mux; an out-of-range select yields an all-zero phrase.
    always_comb begin
        sel_phrase = '0;
        sel_bad    = (bus.sel > SELW'(NSRC));
        if (bus.sel == '0) begin
            sel_phrase = bus.dstd;
        end
        for (int k = 0; k < NSRC; k++) begin
            if (bus.sel == SELW'(k + 1)) begin
                sel_phrase = bus.srcs[k*PW +: PW];
            end
        end
    end

    // Lane shaping: pick the source lane per mode, then zero masked lanes.
    always_comb begin
        shaped = '0;
        for (int i = 0; i < LANES; i++) begin
            int src_lane;
            case (s1_mode_q)
                MODE_BCAST: src_lane = 0;
                MODE_SWAP:  src_lane = (i + HALF) % LANES;
                default:    src_lane = i;
            endcase
            if (s1_lane_en_q[i]) begin
                shaped[i*LW +: LW] = s1_data_q[src_lane*LW +: LW];
            end
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        s1_mode_d    = s1_mode_q;
        s1_lane_en_d = s1_lane_en_q;
        out_valid_d  = out_valid_q;
        adda_d       = adda_q;
        illegal_d    = illegal_q;
        xfer_cnt_d   = xfer_cnt_q;

        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_data_d    = sel_phrase;
            s1_mode_d    = bus.mode;
            s1_lane_en_d = bus.lane_en;
            if (sel_bad) begin
                illegal_d = 1'b1;
            end
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            out_valid_d = 1'b1;
            adda_d      = shaped;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end

        // Free-running wrap is intended; no overflow indication.
        if (drain) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_mode_q    <= MODE_PASS;
            s1_lane_en_q <= '0;
            out_valid_q  <= 1'b0;
            adda_q       <= '0;
            illegal_q    <= 1'b0;
            xfer_cnt_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_mode_q    <= s1_mode_d;
            s1_lane_en_q <= s1_lane_en_d;
            out_valid_q  <= out_valid_d;
            adda_q       <= adda_d;
            illegal_q    <= illegal_d;
            xfer_cnt_q   <= xfer_cnt_d;
        end
    end
endmodule

// File: tb/tb_dadda_pipe.sv
// Directed bench for dadda_pipe: expected phrases are queued on accept and
// checked by an independent output monitor.
module tb_dadda_pipe;
    localparam int LW    = 16;
    localparam int LANES = 4;
    localparam int NSRC  = 5;
    localparam int SELW  = 3;
    localparam int PW    = LANES * LW;

    logic        sys_clk;
    logic        reset;
    logic        illegal_sel;
    logic [15:0] xfer_cnt;

    dadda_pipe_if #(.LW(LW), .LANES(LANES), .NSRC(NSRC), .SELW(SELW)) bus ();

    dadda_pipe #(.LW(LW), .LANES(LANES), .NSRC(NSRC), .SELW(SELW)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .bus         (bus),
        .illegal_sel (illegal_sel),
        .xfer_cnt    (xfer_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] held_adda;
    logic          held_valid = 1'b0;
    logic          in_ready_low_seen = 1'b0;
    logic [NSRC*PW-1:0] srcs_v;

    // Clock / reset
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: present one phrase and hold it until accepted.
    task automatic send(input logic [PW-1:0] d, input logic [NSRC*PW-1:0] s,
                        input logic [SELW-1:0] sl, input logic [1:0] md,
                        input logic [LANES-1:0] le, input logic [PW-1:0] exp);
        int t;
        bus.dstd     = d;
        bus.srcs     = s;
        bus.sel      = sl;
        bus.mode     = md;
        bus.lane_en  = le;
        bus.in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge sys_clk);
            if (bus.in_ready) break;
            in_ready_low_seen = 1'b1;
            t++;
            if (t > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
                bus.in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(exp);
        @(posedge sys_clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain_wait();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge sys_clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        @(posedge sys_clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor: compare on every completed transfer, and check
    // adda holds while the consumer stalls.
    always @(negedge sys_clk) begin
        if (reset) begin
            held_valid <= 1'b0;
        end else begin
            if (bus.out_valid && !bus.out_ready) begin
                if (held_valid) check("stall_hold", bus.adda, held_adda);
                held_adda  <= bus.adda;
                held_valid <= 1'b1;
            end else begin
                held_valid <= 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %h expected no transfer", bus.adda);
                end else begin
                    check("adda", bus.adda, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.dstd     = '0;
        bus.srcs     = '0;
        bus.sel      = '0;
        bus.mode     = 2'b00;
        bus.lane_en  = '0;
        bus.out_ready = 1'b0;
        srcs_v       = '0;
        srcs_v[2*PW +: PW] = 64'hDDDD_CCCC_BBBB_AAAA;

        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_out_valid", PW'(bus.out_valid), '0);
        check("rst_adda", bus.adda, '0);
        check("rst_xfer_cnt", PW'(xfer_cnt), '0);
        check("rst_illegal", PW'(illegal_sel), '0);
        reset = 1'b0;
        @(posedge sys_clk);
        #1;
        check("rst_in_ready", PW'(bus.in_ready), PW'(1));

        // Pass-through and two-edge latency
        bus.out_ready = 1'b1;
        send(64'h4444_3333_2222_1111, srcs_v, 3'd0, 2'b00, 4'b1111, 64'h4444_3333_2222_1111);
        check("lat_s1_only", PW'(bus.out_valid), '0);
        @(posedge sys_clk);
        #1;
        check("lat_out_valid", PW'(bus.out_valid), PW'(1));
        check("lat_adda", bus.adda, 64'h4444_3333_2222_1111);
        drain_wait();
        check("xfer_cnt_1", PW'(xfer_cnt), PW'(1));

        // Broadcast with lane 2 masked, then half swap
        send(64'h0, srcs_v, 3'd3, 2'b01, 4'b1011, 64'hAAAA_0000_AAAA_AAAA);
        send(64'h0, srcs_v, 3'd3, 2'b10, 4'b1111, 64'hBBBB_AAAA_DDDD_CCCC);
        send(64'h0, srcs_v, 3'd3, 2'b11, 4'b0110, 64'h0000_CCCC_BBBB_0000);
        drain_wait();
        check("xfer_cnt_4", PW'(xfer_cnt), PW'(4));

        // Stream of four with a consumer stall in cycles 3..7
        do_reset();
        in_ready_low_seen = 1'b0;
        fork
            begin
                send(64'h0001_0002_0003_0004, srcs_v, 3'd0, 2'b00, 4'b1111, 64'h0001_0002_0003_0004);
                send(64'h0011_0012_0013_0014, srcs_v, 3'd0, 2'b00, 4'b1111, 64'h0011_0012_0013_0014);
                send(64'h0021_0022_0023_0024, srcs_v, 3'd0, 2'b00, 4'b1111, 64'h0021_0022_0023_0024);
                send(64'h0031_0032_0033_0034, srcs_v, 3'd0, 2'b00, 4'b1111, 64'h0031_0032_0033_0034);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    bus.out_ready = !(c >= 3 && c <= 7);
                    if (c == 5) begin
                        @(negedge sys_clk);
                        check("full_in_ready", PW'(bus.in_ready), '0);
                        check("full_out_valid", PW'(bus.out_valid), PW'(1));
                    end
                    @(posedge sys_clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain_wait();
        check("stream_in_ready_drop", PW'(in_ready_low_seen), PW'(1));
        check("stream_xfer_cnt", PW'(xfer_cnt), PW'(4));

        // Illegal select is zeroed and sticky
        send(64'h1234_5678_9ABC_DEF0, srcs_v, 3'd7, 2'b00, 4'b1111, 64'h0);
        check("illegal_set", PW'(illegal_sel), PW'(1));
        send(64'h1234_5678_9ABC_DEF0, srcs_v, 3'd0, 2'b00, 4'b1111, 64'h1234_5678_9ABC_DEF0);
        send(64'h0, srcs_v, 3'd6, 2'b00, 4'b1111, 64'h0);
        drain_wait();
        check("illegal_sticky", PW'(illegal_sel), PW'(1));
        do_reset();
        check("illegal_cleared", PW'(illegal_sel), '0);

        // Counter wrap
        for (int i = 0; i < 65535; i++) begin
            send(PW'(i), srcs_v, 3'd0, 2'b00, 4'b1111, PW'(i));
        end
        drain_wait();
        check("xfer_cnt_ffff", PW'(xfer_cnt), PW'(16'hFFFF));
        send(64'hCAFE, srcs_v, 3'd0, 2'b00, 4'b1111, 64'hCAFE);
        drain_wait();
        check("xfer_cnt_wrap", PW'(xfer_cnt), '0);
        send(64'hBEEF, srcs_v, 3'd0, 2'b00, 4'b1111, 64'hBEEF);
        drain_wait();

        // Asynchronous reset while holding a valid output
        bus.out_ready = 1'b0;
        send(64'h5555_6666_7777_8888, srcs_v, 3'd0, 2'b00, 4'b1111, 64'h5555_6666_7777_8888);
        @(posedge sys_clk);
        #1;
        check("pre_rst_out_valid", PW'(bus.out_valid), PW'(1));
        check("pre_rst_xfer_cnt", PW'(xfer_cnt), PW'(1));
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_out_valid", PW'(bus.out_valid), '0);
        check("async_adda", bus.adda, '0);
        check("async_xfer_cnt", PW'(xfer_cnt), '0);
        @(posedge sys_clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        send(64'h0F0F_0F0F_0F0F_0F0F, srcs_v, 3'd0, 2'b10, 4'b0011, 64'h0000_0000_0F0F_0F0F);
        drain_wait();
        check("post_rst_xfer_cnt", PW'(xfer_cnt), PW'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
